axi_mem_responder: RTL and testbench
====================================

AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, meaning AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 512, meaning AXI data width in bits; a power of two, at least 32.
REQ-003 SHALL have parameter DEPTH, default 1024, meaning number of DATA_WIDTH words stored; a power of two.
REQ-004 SHALL have ports:
- ap_clk, in, 1: sole clock.
- ap_rst_n, in, 1: reset, asynchronous, active-low.
- s_axi_awvalid, in, 1: write address valid.
- s_axi_awready, out, 1: write address ready.
- s_axi_awaddr, in, ADDR_WIDTH: write byte address.
- s_axi_awlen, in, 8: write beats minus one.
- s_axi_wvalid, in, 1: write data valid.
- s_axi_wready, out, 1: write data ready.
- s_axi_wdata, in, DATA_WIDTH: write data.
- s_axi_wstrb, in, DATA_WIDTH/8: byte enables.
- s_axi_wlast, in, 1: last write beat.
- s_axi_bvalid, out, 1: write response valid.
- s_axi_bready, in, 1: write response ready.
- s_axi_arvalid, in, 1: read address valid.
- s_axi_arready, out, 1: read address ready.
- s_axi_araddr, in, ADDR_WIDTH: read byte address.
- s_axi_arlen, in, 8: read beats minus one.
- s_axi_rvalid, out, 1: read data valid.
- s_axi_rready, in, 1: read data ready.
- s_axi_rdata, out, DATA_WIDTH: read data.
- s_axi_rlast, out, 1: last read beat.
- wlast_err, out, 1: sticky flag for wlast/awlen mismatch.
REQ-005 SHALL be the slave end of the four m0x master ports of the accelerator top level; signal set matches exactly; no id, size, burst, resp signals.

Function
REQ-006 SHALL store DEPTH words; word index = (byte addr >> log2(DATA_WIDTH/8)) mod DEPTH; low address bits ignored; INCR bursts only.
REQ-007 SHALL increment word index by one per accepted beat, wrapping DEPTH-1 -> 0 within a burst.
REQ-008 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; awready=1 only in W_IDLE; wready=1 only in W_DATA; bvalid=1 only in W_RESP.
REQ-009 W_IDLE->W_DATA on awvalid&awready, latching index and awlen; W_DATA->W_RESP on the handshake of beat awlen+1; W_RESP->W_IDLE on bready&bvalid.
REQ-010 SHALL write each byte lane i of a W_DATA beat only when wstrb[i]=1; zero-strobe beats still count.
REQ-011 SHALL terminate the burst by beat count, not wlast; wlast=0 on the final beat or wlast=1 on an earlier beat sets wlast_err=1 until reset.
REQ-012 Read FSM SHALL have states R_IDLE, R_DATA, independent of the write FSM; arready=1 only in R_IDLE; rvalid=1 only in R_DATA.
REQ-013 Handshake on AR at cycle N SHALL give rvalid=1 with the first beat at cycle N+1; following beats SHALL be presented the cycle after each rvalid&rready, with no bubbles while rready=1.
REQ-014 rdata and rlast SHALL stay stable while rvalid=1 and rready=0; rlast=1 only on beat arlen+1; after that beat's handshake, return to R_IDLE, with arready=1 the next cycle.
REQ-015 Read and write to the same word in the same cycle SHALL return the pre-write data.
REQ-016 awlen=0 / arlen=0 SHALL give single-beat bursts (rlast=1 on first beat).
REQ-017 Only one outstanding write and one outstanding read SHALL exist; no AW/AR acceptance until the current burst completes.

Reset
REQ-018 While ap_rst_n=0, and asynchronously on its assertion: awready=0, wready=0, bvalid=0, arready=0, rvalid=0, rlast=0, rdata=0, wlast_err=0; both FSMs idle.
REQ-019 Reset asserted mid-burst SHALL abandon the burst without a response; memory contents are not cleared; words already written keep their data.
REQ-020 awready and arready SHALL be 1 on the first clock edge after ap_rst_n deasserts.

Verification
REQ-021 AW addr 0x40, awlen=3, data A0..A3 with full strobes, bready=1 -> bvalid exactly one cycle after the 4th beat. AR 0x40, arlen=3 -> rdata A0..A3, rlast only on A3.
REQ-022 Write word 5 = all-FF, then a beat to word 5 of 0x00 with wstrb=0x1 -> read word 5 = FF..FF00.
REQ-023 Read burst arlen=7 with rready toggled 1,0,0,1 -> every beat delivered exactly once, in order, with rdata held stable during stalls.
REQ-024 Write at index DEPTH-2 with awlen=3 -> data lands in words DEPTH-2, DEPTH-1, 0, 1; readback matches.
REQ-025 awlen=1 with wlast=1 on beat 1 -> wlast_err=1, burst still completes after 2 beats; ap_rst_n pulse clears wlast_err to 0.
REQ-026 ap_rst_n=0 in the middle of a 4-beat read -> rvalid=0 immediately; after release, arready=1 and a new read returns the correct data.

Source files
------------

// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI-style slave memory model with DEPTH words of DATA_WIDTH bits.
// The write and read channels are independent. Each channel has at most one burst
// outstanding. Bursts are INCR only, and the word index wraps modulo DEPTH.
//
// Ports:
//   ap_clk, ap_rst_n        clock; asynchronous active-low reset
//   s_axi_aw*               write address: valid/ready, byte address, beats minus one
//   s_axi_w*                write data: valid/ready, data, byte strobes, last
//   s_axi_b*                write response: valid/ready
//   s_axi_ar*               read address: valid/ready, byte address, beats minus one
//   s_axi_r*                read data: valid/ready, data, last
//   wlast_err               sticky flag; set when wlast disagrees with the awlen beat count
module axi_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic                    s_axi_rlast,
  output logic                    wlast_err
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned OFF_WIDTH  = $clog2(STRB_WIDTH);
  localparam int unsigned IDX_WIDTH  = $clog2(DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  // Storage: not reset, so contents survive a reset pulse.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // The byte offset and the bits above the index are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

  logic [IDX_WIDTH-1:0] aw_idx, ar_idx;
  assign aw_idx = s_axi_awaddr[OFF_WIDTH +: IDX_WIDTH];
  assign ar_idx = s_axi_araddr[OFF_WIDTH +: IDX_WIDTH];

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  w_state_e             w_state_q;
  logic [IDX_WIDTH-1:0] w_idx_q;
  logic [7:0]           w_len_q;
  logic [7:0]           w_cnt_q;
  logic                 awready_q, wready_q, bvalid_q, wlast_err_q;
  logic                 w_beat, w_final;

  assign w_beat  = (w_state_q == W_DATA) && s_axi_wvalid && wready_q;
  assign w_final = (w_cnt_q == w_len_q);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      w_state_q   <= W_IDLE;
      w_idx_q     <= '0;
      w_len_q     <= '0;
      w_cnt_q     <= '0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      wlast_err_q <= 1'b0;
    end else begin
      unique case (w_state_q)
        W_IDLE: begin
          if (s_axi_awvalid && awready_q) begin
            w_state_q <= W_DATA;
            w_idx_q   <= aw_idx;
            w_len_q   <= s_axi_awlen;
            w_cnt_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
          end else begin
            // Also the first-edge-after-reset path that raises awready.
            awready_q <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_beat) begin
            w_idx_q <= w_idx_q + 1'b1;
            w_cnt_q <= w_cnt_q + 8'd1;
            // The beat count ends the burst; wlast is only checked against it.
            if (s_axi_wlast != w_final) begin
              wlast_err_q <= 1'b1;
            end
            if (w_final) begin
              w_state_q <= W_RESP;
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            w_state_q <= W_IDLE;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // Byte-lane write. A zero-strobe beat still advances the burst above.
  always_ff @(posedge ap_clk) begin
    if (w_beat) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (s_axi_wstrb[i]) begin
          mem[w_idx_q][8*i +: 8] <= s_axi_wdata[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  r_state_e              r_state_q;
  logic [IDX_WIDTH-1:0]  r_idx_q;   // index of the next beat to fetch
  logic [7:0]            r_len_q;
  logic [7:0]            r_cnt_q;   // index of the beat currently presented
  logic                  arready_q, rvalid_q, rlast_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      unique case (r_state_q)
        R_IDLE: begin
          if (s_axi_arvalid && arready_q) begin
            // Fetch the first beat on the AR edge so rvalid rises the next cycle.
            // A same-edge write is not yet visible, so the old word is returned.
            r_state_q <= R_DATA;
            rdata_q   <= mem[ar_idx];
            rlast_q   <= (s_axi_arlen == 8'd0);
            r_idx_q   <= ar_idx + 1'b1;
            r_len_q   <= s_axi_arlen;
            r_cnt_q   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            if (rlast_q) begin
              r_state_q <= R_IDLE;
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
            end else begin
              rdata_q <= mem[r_idx_q];
              r_idx_q <= r_idx_q + 1'b1;
              r_cnt_q <= r_cnt_q + 8'd1;
              rlast_q <= ((r_cnt_q + 8'd1) == r_len_q);
            end
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign wlast_err     = wlast_err_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rdata   = rdata_q;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder.
// Writes update a reference memory in the bench. Reads push the expected beats into a
// scoreboard queue, and those beats are popped when the read handshake occurs.
module tb_axi_mem_responder;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned DEPTH      = 16;
  localparam int          TMO        = 40;

  logic                    ap_clk = 1'b0;
  logic                    ap_rst_n;
  logic                    s_axi_awvalid, s_axi_awready;
  logic [ADDR_WIDTH-1:0]   s_axi_awaddr;
  logic [7:0]              s_axi_awlen;
  logic                    s_axi_wvalid, s_axi_wready;
  logic [DATA_WIDTH-1:0]   s_axi_wdata;
  logic [DATA_WIDTH/8-1:0] s_axi_wstrb;
  logic                    s_axi_wlast;
  logic                    s_axi_bvalid, s_axi_bready;
  logic                    s_axi_arvalid, s_axi_arready;
  logic [ADDR_WIDTH-1:0]   s_axi_araddr;
  logic [7:0]              s_axi_arlen;
  logic                    s_axi_rvalid, s_axi_rready;
  logic [DATA_WIDTH-1:0]   s_axi_rdata;
  logic                    s_axi_rlast;
  logic                    wlast_err;

  axi_mem_responder #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_awaddr (s_axi_awaddr),
    .s_axi_awlen  (s_axi_awlen),
    .s_axi_wvalid (s_axi_wvalid),
    .s_axi_wready (s_axi_wready),
    .s_axi_wdata  (s_axi_wdata),
    .s_axi_wstrb  (s_axi_wstrb),
    .s_axi_wlast  (s_axi_wlast),
    .s_axi_bvalid (s_axi_bvalid),
    .s_axi_bready (s_axi_bready),
    .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_araddr (s_axi_araddr),
    .s_axi_arlen  (s_axi_arlen),
    .s_axi_rvalid (s_axi_rvalid),
    .s_axi_rready (s_axi_rready),
    .s_axi_rdata  (s_axi_rdata),
    .s_axi_rlast  (s_axi_rlast),
    .wlast_err    (wlast_err)
  );

  always #5 ap_clk = ~ap_clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [DATA_WIDTH-1:0]   model [DEPTH];
  logic [DATA_WIDTH-1:0]   wbuf  [16];
  logic [DATA_WIDTH/8-1:0] sbuf  [16];
  logic [DATA_WIDTH-1:0]   exp_q [$];
  logic                    last_q[$];
  int                      rr_pat [4] = '{1, 0, 0, 1};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Beat b carries wbuf[b]/sbuf[b]. A non-negative early_last
  // puts wlast on that beat instead of the final beat.
  task automatic do_write(input int idx, input int len, input int early_last);
    int n;
    s_axi_awaddr  = ADDR_WIDTH'(idx * 8);
    s_axi_awlen   = 8'(len);
    s_axi_awvalid = 1'b1;
    n = 0;
    while (s_axi_awready !== 1'b1 && n < TMO) begin @(negedge ap_clk); n++; end
    if (n >= TMO) check("aw_timeout", 64'd0, 64'd1);
    @(negedge ap_clk);
    s_axi_awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      s_axi_wvalid = 1'b1;
      s_axi_wdata  = wbuf[b];
      s_axi_wstrb  = sbuf[b];
      s_axi_wlast  = (early_last < 0) ? (b == len) : (b == early_last);
      n = 0;
      while (s_axi_wready !== 1'b1 && n < TMO) begin @(negedge ap_clk); n++; end
      if (n >= TMO) check("w_timeout", 64'd0, 64'd1);
      check("b_not_early", 64'(s_axi_bvalid), 64'd0);
      for (int i = 0; i < DATA_WIDTH / 8; i++) begin
        if (sbuf[b][i]) model[(idx + b) % DEPTH][8*i +: 8] = wbuf[b][8*i +: 8];
      end
      @(negedge ap_clk);
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
    check("b_valid_after_last", 64'(s_axi_bvalid), 64'd1);
    @(negedge ap_clk);
    check("b_done", 64'(s_axi_bvalid), 64'd0);
    check("aw_ready_back", 64'(s_axi_awready), 64'd1);
  endtask

  // Called at a negedge. With stall set, rready follows rr_pat; otherwise it stays 1.
  task automatic do_read(input int idx, input int len, input bit stall);
    int n;
    int beat;
    for (int b = 0; b <= len; b++) begin
      exp_q.push_back(model[(idx + b) % DEPTH]);
      last_q.push_back(b == len);
    end
    s_axi_araddr  = ADDR_WIDTH'(idx * 8);
    s_axi_arlen   = 8'(len);
    s_axi_arvalid = 1'b1;
    n = 0;
    while (s_axi_arready !== 1'b1 && n < TMO) begin @(negedge ap_clk); n++; end
    if (n >= TMO) check("ar_timeout", 64'd0, 64'd1);
    @(negedge ap_clk);
    s_axi_arvalid = 1'b0;
    beat = 0;
    n    = 0;
    while (beat <= len && n < 200) begin
      s_axi_rready = stall ? (rr_pat[n % 4] != 0) : 1'b1;
      check("r_valid", 64'(s_axi_rvalid), 64'd1);
      if (exp_q.size() > 0) begin
        check("r_data", s_axi_rdata, exp_q[0]);
        check("r_last", 64'(s_axi_rlast), 64'(last_q[0]));
      end
      if (s_axi_rready) begin
        void'(exp_q.pop_front());
        void'(last_q.pop_front());
        beat++;
      end
      @(negedge ap_clk);
      n++;
    end
    if (n >= 200) check("r_timeout", 64'd0, 64'd1);
    s_axi_rready = 1'b0;
    check("r_done_valid", 64'(s_axi_rvalid), 64'd0);
    check("r_done_arready", 64'(s_axi_arready), 64'd1);
    check("r_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    ap_rst_n      = 1'b0;
    s_axi_awvalid = 1'b0;
    s_axi_awaddr  = '0;
    s_axi_awlen   = '0;
    s_axi_wvalid  = 1'b0;
    s_axi_wdata   = '0;
    s_axi_wstrb   = '0;
    s_axi_wlast   = 1'b0;
    s_axi_bready  = 1'b1;
    s_axi_arvalid = 1'b0;
    s_axi_araddr  = '0;
    s_axi_arlen   = '0;
    s_axi_rready  = 1'b0;

    // Reset state
    #12;
    check("rst_awready", 64'(s_axi_awready), 64'd0);
    check("rst_wready", 64'(s_axi_wready), 64'd0);
    check("rst_bvalid", 64'(s_axi_bvalid), 64'd0);
    check("rst_arready", 64'(s_axi_arready), 64'd0);
    check("rst_rvalid", 64'(s_axi_rvalid), 64'd0);
    check("rst_rlast", 64'(s_axi_rlast), 64'd0);
    check("rst_rdata", s_axi_rdata, 64'd0);
    check("rst_wlast_err", 64'(wlast_err), 64'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check("post_rst_awready", 64'(s_axi_awready), 64'd1);
    check("post_rst_arready", 64'(s_axi_arready), 64'd1);

    // Four-beat burst at 0x40 (word 8), then read it back
    for (int b = 0; b < 4; b++) begin
      wbuf[b] = {8{8'(8'hA0 + b)}};
      sbuf[b] = 8'hFF;
    end
    do_write(8, 3, -1);
    do_read(8, 3, 1'b0);

    // Partial strobe: only lane 0 is overwritten
    wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    sbuf[0] = 8'hFF;
    do_write(5, 0, -1);
    wbuf[0] = 64'h0;
    sbuf[0] = 8'h01;
    do_write(5, 0, -1);
    check("strb_model", model[5], 64'hFFFF_FFFF_FFFF_FF00);
    do_read(5, 0, 1'b0);

    // Eight random words at index 0, read back with rready toggling
    for (int b = 0; b < 8; b++) begin
      wbuf[b] = {$urandom, $urandom};
      sbuf[b] = 8'hFF;
    end
    do_write(0, 7, -1);
    do_read(0, 7, 1'b1);

    // Burst wrapping from DEPTH-2 to 1, with a zero-strobe beat in the middle
    for (int b = 0; b < 4; b++) begin
      wbuf[b] = {$urandom, $urandom};
      sbuf[b] = (b == 2) ? 8'h00 : 8'hFF;
    end
    do_write(DEPTH - 2, 3, -1);
    do_read(DEPTH - 2, 3, 1'b0);
    do_read(0, 1, 1'b1);
    check("no_wlast_err_yet", 64'(wlast_err), 64'd0);

    // Early wlast still completes after awlen+1 beats and sets the sticky flag
    wbuf[0] = 64'h1111_2222_3333_4444;
    wbuf[1] = 64'h5555_6666_7777_8888;
    sbuf[0] = 8'hFF;
    sbuf[1] = 8'hFF;
    do_write(12, 1, 0);
    check("wlast_err_set", 64'(wlast_err), 64'd1);
    @(negedge ap_clk);
    check("wlast_err_sticky", 64'(wlast_err), 64'd1);
    ap_rst_n = 1'b0;
    #1;
    check("wlast_err_cleared", 64'(wlast_err), 64'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    do_read(12, 1, 1'b0);

    // Reset in the middle of a 4-beat read; memory must survive
    s_axi_araddr  = ADDR_WIDTH'(8 * 8);
    s_axi_arlen   = 8'd3;
    s_axi_arvalid = 1'b1;
    @(negedge ap_clk);
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b1;
    check("mid_rst_beat0", s_axi_rdata, model[8]);
    @(negedge ap_clk);
    s_axi_rready = 1'b0;
    check("mid_rst_beat1", s_axi_rdata, model[9]);
    check("mid_rst_rvalid_before", 64'(s_axi_rvalid), 64'd1);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("mid_rst_rvalid", 64'(s_axi_rvalid), 64'd0);
    check("mid_rst_rlast", 64'(s_axi_rlast), 64'd0);
    check("mid_rst_rdata", s_axi_rdata, 64'd0);
    check("mid_rst_arready", 64'(s_axi_arready), 64'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check("mid_rst_arready_after", 64'(s_axi_arready), 64'd1);
    do_read(8, 3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog expired");
  end

endmodule
